// File: rtl/timer_alarm_sched_pkg.sv
// Shared types and constants for the software alarm scheduler that
// multiplexes several alarm slots onto one mtimecmp comparator.
package timer_alarm_sched_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StProg = 2'd2
  } sched_state_e;

  typedef enum logic {
    AlarmArm    = 1'b0,
    AlarmCancel = 1'b1
  } alarm_op_e;

  // Comparator value when nothing is armed: never matches a real mtime.
  localparam logic [63:0] CmpReset = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/timer_alarm_sched.sv
// Alarm scheduler: keeps per-slot deadlines, rescans for the earliest armed
// deadline after every command or expiry, and programs the shared comparator.
module timer_alarm_sched
  import timer_alarm_sched_pkg::*;
#(
  parameter int NumAlarms = 4,
  parameter int IdW       = $clog2(NumAlarms)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [63:0]          mtime_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_op_i,
  input  logic [IdW-1:0]       req_id_i,
  input  logic [63:0]          req_deadline_i,
  output logic [63:0]          cmp_o,
  output logic                 cmp_update_o,
  output logic                 cmp_valid_o,
  output logic [NumAlarms-1:0] expired_o,
  output logic [NumAlarms-1:0] armed_o
);

  localparam logic [IdW-1:0] LastSlot = IdW'(NumAlarms - 1);
  localparam logic [IdW:0]   SlotCnt  = (IdW + 1)'(NumAlarms);

  sched_state_e state_q, state_d;

  logic [63:0]          deadline_q [NumAlarms];
  logic [NumAlarms-1:0] armed_q;
  logic [63:0]          cmp_q;
  logic                 cmp_valid_q;
  logic [IdW-1:0]       cur_id_q;

  // running minimum of the in-progress scan
  logic [IdW-1:0]       scan_idx_q;
  logic [63:0]          best_val_q;
  logic [IdW-1:0]       best_id_q;
  logic                 best_found_q;

  logic                 hit, accept, start_scan, scan_last, slot_ok;
  logic                 take, found_n;
  logic [63:0]          val_n;
  logic [IdW-1:0]       id_n;

  assign slot_ok   = {1'b0, req_id_i} < SlotCnt;
  assign scan_last = (state_q == StScan) && (scan_idx_q == LastSlot);

  // Strict less-than keeps the earlier slot on equal deadlines.
  always_comb begin
    take    = armed_q[scan_idx_q] &&
              (!best_found_q || (deadline_q[scan_idx_q] < best_val_q));
    found_n = best_found_q | take;
    val_n   = take ? deadline_q[scan_idx_q] : best_val_q;
    id_n    = take ? scan_idx_q : best_id_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    hit          = 1'b0;
    accept       = 1'b0;
    start_scan   = 1'b0;
    req_ready_o  = 1'b0;
    cmp_update_o = 1'b0;
    expired_o    = '0;
    case (state_q)
      StIdle: begin
        hit         = cmp_valid_q && (mtime_i >= cmp_q);
        req_ready_o = !hit;
        accept      = req_valid_i && !hit;
        if (hit) expired_o[cur_id_q] = 1'b1;
        if (hit || accept) begin
          start_scan = 1'b1;
          state_d    = StScan;
        end
      end
      StScan: if (scan_last) state_d = StProg;
      StProg: begin
        cmp_update_o = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The comparator is loaded as the scan finishes so the new value is
  // already on cmp_o during the update strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumAlarms; i++) deadline_q[i] <= '0;
      armed_q      <= '0;
      cmp_q        <= CmpReset;
      cmp_valid_q  <= 1'b0;
      cur_id_q     <= '0;
      scan_idx_q   <= '0;
      best_val_q   <= CmpReset;
      best_id_q    <= '0;
      best_found_q <= 1'b0;
    end else begin
      if (hit) armed_q[cur_id_q] <= 1'b0;
      if (accept && slot_ok) begin
        if (alarm_op_e'(req_op_i) == AlarmArm) begin
          deadline_q[req_id_i] <= req_deadline_i;
          armed_q[req_id_i]    <= 1'b1;
        end else begin
          armed_q[req_id_i]    <= 1'b0;
        end
      end
      if (start_scan) begin
        scan_idx_q   <= '0;
        best_val_q   <= CmpReset;
        best_id_q    <= '0;
        best_found_q <= 1'b0;
      end else if (state_q == StScan) begin
        scan_idx_q   <= scan_idx_q + 1'b1;
        best_val_q   <= val_n;
        best_id_q    <= id_n;
        best_found_q <= found_n;
        if (scan_last) begin
          cmp_q       <= found_n ? val_n : CmpReset;
          cmp_valid_q <= found_n;
          cur_id_q    <= found_n ? id_n : '0;
        end
      end
    end
  end

  assign cmp_o       = cmp_q;
  assign cmp_valid_o = cmp_valid_q;
  assign armed_o     = armed_q;

  a_expired_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(expired_o));
  a_update_in_prog: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cmp_update_o |-> (state_q == StProg));
  a_ready_in_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != StIdle) |-> !req_ready_o);

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Self-checking bench: directed/table scenarios plus random traffic, all
// cross-checked every cycle against a slot-list reference model.
module tb_timer_alarm_sched;
  import timer_alarm_sched_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic [63:0]   mtime = '0;
  logic          req_valid = 1'b0, req_op = 1'b0;
  logic [IW-1:0] req_id = '0;
  logic [63:0]   req_dl = '0;
  logic          req_ready, cmp_update, cmp_valid;
  logic [63:0]   cmp;
  logic [N-1:0]  expired, armed;

  int checks = 0, errors = 0;

  timer_alarm_sched #(.NumAlarms(N), .IdW(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mtime_i(mtime),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_id_i(req_id), .req_deadline_i(req_dl),
    .cmp_o(cmp), .cmp_update_o(cmp_update), .cmp_valid_o(cmp_valid),
    .expired_o(expired), .armed_o(armed)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot list, current comparator, and a countdown of
  // cycles the scheduler stays busy after an accepted command or expiry.
  bit          m_armed [N];
  logic [63:0] m_dl [N];
  logic [63:0] m_cmp = '1;
  bit          m_valid = 1'b0;
  int          m_cur = 0;
  int          m_busy = 0;

  always @(negedge clk_i) begin : mon
    bit           hit, e_ready, e_upd, found;
    logic [N-1:0] e_exp, e_arm;
    logic [63:0]  best;
    int           bi;
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin m_armed[i] = 0; m_dl[i] = '0; end
      m_cmp = '1; m_valid = 0; m_cur = 0; m_busy = 0;
      chk("rst cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst cmp_valid", 64'(cmp_valid), 0);
      chk("rst cmp_update", 64'(cmp_update), 0);
      chk("rst expired", 64'(expired), 0);
      chk("rst armed", 64'(armed), 0);
    end else begin
      hit = 0; e_ready = 0; e_upd = 0; e_exp = '0;
      if (m_busy == 0) begin
        hit = m_valid && (mtime >= m_cmp);
        e_ready = !hit;
        if (hit) e_exp[m_cur] = 1'b1;
      end else begin
        e_upd = (m_busy == 1);
      end
      for (int i = 0; i < N; i++) e_arm[i] = m_armed[i];
      chk("mdl ready", 64'(req_ready), 64'(e_ready));
      chk("mdl expired", 64'(expired), 64'(e_exp));
      chk("mdl cmp_update", 64'(cmp_update), 64'(e_upd));
      chk("mdl cmp", cmp, m_cmp);
      chk("mdl cmp_valid", 64'(cmp_valid), 64'(m_valid));
      chk("mdl armed", 64'(armed), 64'(e_arm));
      if (m_busy == 0) begin
        if (hit) begin
          m_armed[m_cur] = 0; m_busy = N + 1;
        end else if (req_valid) begin
          if (req_op == 1'b0) begin m_dl[req_id] = req_dl; m_armed[req_id] = 1; end
          else m_armed[req_id] = 0;
          m_busy = N + 1;
        end
      end else begin
        if (m_busy == 2) begin
          found = 0; best = '1; bi = 0;
          for (int i = 0; i < N; i++)
            if (m_armed[i] && (!found || m_dl[i] < best)) begin
              found = 1; best = m_dl[i]; bi = i;
            end
          m_valid = found; m_cmp = found ? best : '1; m_cur = bi;
        end
        m_busy--;
      end
    end
  end

  task automatic send(input logic op, input int id, input logic [63:0] dl);
    bit done = 0;
    req_valid = 1; req_op = op; req_id = IW'(id); req_dl = dl;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk_i); done = req_ready;
      @(posedge clk_i); #1;
    end
    req_valid = 0;
    chk("handshake", 64'(done), 1);
  endtask

  task automatic wait_update(input string name);
    int lat;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk_i);
      if (cmp_update) break;
      @(posedge clk_i); #1;
    end
    if (lat <= 40) begin @(posedge clk_i); #1; end
    chk({name, " latency"}, 64'(lat), 64'(N + 1));
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  typedef struct {
    logic        op;
    int          id;
    logic [63:0] dl;
    logic [63:0] e_cmp;
    bit          e_valid;
    logic [N-1:0] e_armed;
  } vec_t;

  vec_t tbl [10];

  initial begin
    bit hs;
    int n;
    tbl[0] = '{1'b0, 2, 64'd100, 64'd100, 1'b1, 4'b0100};
    tbl[1] = '{1'b0, 0, 64'd500, 64'd100, 1'b1, 4'b0101};
    tbl[2] = '{1'b0, 1, 64'd300, 64'd100, 1'b1, 4'b0111};
    tbl[3] = '{1'b0, 2, 64'd700, 64'd300, 1'b1, 4'b0111};
    tbl[4] = '{1'b0, 3, 64'd300, 64'd300, 1'b1, 4'b1111};
    tbl[5] = '{1'b1, 1, 64'd0,   64'd300, 1'b1, 4'b1101};
    tbl[6] = '{1'b1, 1, 64'd0,   64'd300, 1'b1, 4'b1101};
    tbl[7] = '{1'b1, 3, 64'd0,   64'd500, 1'b1, 4'b0101};
    tbl[8] = '{1'b1, 0, 64'd0,   64'd700, 1'b1, 4'b0100};
    tbl[9] = '{1'b1, 2, 64'd0,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'b0000};

    #1 rst_ni = 0;
    repeat (2) tick();
    @(negedge clk_i);
    chk("reset cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("reset armed", 64'(armed), 0);
    tick(); rst_ni = 1;
    tick();

    // table: command sequence at mtime 0, nothing expires
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].op, tbl[i].id, tbl[i].dl);
      wait_update($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d cmp", i), cmp, tbl[i].e_cmp);
      chk($sformatf("tbl%0d valid", i), 64'(cmp_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d armed", i), 64'(armed), 64'(tbl[i].e_armed));
    end

    // single alarm reaching its deadline
    mtime = 0;
    send(1'b0, 2, 64'd100); wait_update("a2");
    chk("a2 cmp", cmp, 64'd100);
    mtime = 99; @(negedge clk_i); chk("a2 early", 64'(expired), 0);
    tick(); mtime = 100; @(negedge clk_i);
    chk("a2 expired", 64'(expired), 64'b0100);
    chk("a2 ready", 64'(req_ready), 0);
    tick(); wait_update("a2 rescan");
    chk("a2 armed", 64'(armed), 0);
    chk("a2 valid", 64'(cmp_valid), 0);

    // equal deadlines fire lowest index first, back to back
    mtime = 0;
    send(1'b0, 0, 64'd500); wait_update("b0");
    send(1'b0, 1, 64'd300); wait_update("b1");
    send(1'b0, 3, 64'd300); wait_update("b3");
    chk("b cmp", cmp, 64'd300);
    mtime = 300; @(negedge clk_i); chk("b first", 64'(expired), 64'b0010);
    tick(); wait_update("b r1");
    chk("b cmp2", cmp, 64'd300);
    @(negedge clk_i); chk("b second", 64'(expired), 64'b1000);
    tick(); wait_update("b r2");
    chk("b cmp3", cmp, 64'd500);
    @(negedge clk_i); chk("b quiet", 64'(expired), 0);
    tick(); mtime = 500; @(negedge clk_i); chk("b third", 64'(expired), 64'b0001);
    tick(); wait_update("b r3");
    chk("b valid", 64'(cmp_valid), 0);

    // cancel before deadline
    mtime = 0;
    send(1'b0, 1, 64'd200); wait_update("c arm");
    send(1'b1, 1, 64'd0); wait_update("c cancel");
    chk("c valid", 64'(cmp_valid), 0);
    mtime = 250;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); chk("c no fire", 64'(expired), 0); tick();
    end

    // deadline already in the past at arm time
    mtime = 50;
    send(1'b0, 0, 64'd10); wait_update("d arm");
    @(negedge clk_i); chk("d fire", 64'(expired), 64'b0001);
    tick(); wait_update("d rescan");
    chk("d valid", 64'(cmp_valid), 0);

    // request colliding with an expiry hit
    mtime = 0;
    send(1'b0, 2, 64'd100); wait_update("e arm");
    mtime = 100; req_valid = 1; req_op = 0; req_id = 1; req_dl = 64'd400;
    @(negedge clk_i);
    chk("e ready", 64'(req_ready), 0);
    chk("e expired", 64'(expired), 64'b0100);
    n = 0;
    do begin
      tick(); @(negedge clk_i); n++;
    end while (!req_ready && n < 40);
    chk("e wait", 64'(n), 64'(N + 2));
    tick(); req_valid = 0;
    wait_update("e req");
    chk("e cmp", cmp, 64'd400);
    chk("e armed", 64'(armed), 64'b0010);
    send(1'b1, 1, 64'd0); wait_update("e clean");

    // reset in the middle of a scan
    mtime = 0;
    send(1'b0, 0, 64'd1000); wait_update("f arm");
    send(1'b0, 1, 64'd2000);
    tick(); rst_ni = 0;
    @(negedge clk_i);
    chk("f cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("f valid", 64'(cmp_valid), 0);
    chk("f armed", 64'(armed), 0);
    tick(); rst_ni = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i); chk("f no update", 64'(cmp_update), 0); tick();
    end

    // random traffic against the model
    mtime = 64'd1000;
    for (int c = 0; c < 1500; c++) begin
      mtime = mtime + 64'($urandom_range(0, 2));
      if (!req_valid && $urandom_range(0, 2) == 0) begin
        req_valid = 1;
        req_op = ($urandom_range(0, 3) == 0);
        req_id = IW'($urandom_range(0, N - 1));
        req_dl = mtime + 64'($urandom_range(0, 90)) - 64'd10;
      end
      @(negedge clk_i); hs = req_valid && req_ready;
      tick();
      if (hs) req_valid = 0;
    end
    req_valid = 0;
    mtime = 64'hFFFF_FFFF_FFFF_FFFE;
    repeat (6 * (N + 2)) tick();
    chk("drain armed", 64'(armed), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
